// File: rtl/tile_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : tile_scheduler_if
//  Purpose  : Coefficient-update handshake between the time-keeping
//             requester and the tile scheduler.
//  Signals  : upd_valid  requester offers an update
//             upd_ready  scheduler accepts the update this cycle
//             upd_sel    target tile index
//             upd_a/b/c  coefficient set for the target tile
//  Modports : master (requester side), slave (scheduler side)
//  Revision : 1.0  initial release
// ============================================================================
interface tile_scheduler_if #(
    parameter int COEF_W = 54
);
    logic              upd_valid;
    logic              upd_ready;
    logic [1:0]        upd_sel;
    logic [COEF_W-1:0] upd_a;
    logic [COEF_W-1:0] upd_b;
    logic [COEF_W-1:0] upd_c;

    modport master (
        output upd_valid,
        output upd_sel,
        output upd_a,
        output upd_b,
        output upd_c,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_sel,
        input  upd_a,
        input  upd_b,
        input  upd_c,
        output upd_ready
    );
endinterface
`default_nettype wire

// File: rtl/tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tile_scheduler
//  Purpose  : Drives the restart/stepy/stepx command stream for the clock-hand
//             tile evaluators from the raster position, and owns the
//             double-buffered a/b/c coefficient sets of every tile. Updates
//             land in shadow copies at any time and are committed to the live
//             copies once per frame, at frame end, so a hand never tears.
//  Ports    : vga_clk       pixel clock
//             vga_rst_n     asynchronous active-low reset
//             x, y          raster column / row from the timing generator
//             upd           coefficient update handshake (slave side)
//             command       0 idle, 1 restart, 2 stepy, 3 stepx (registered)
//             coef_a/b/c    live coefficients, tile i at [i*COEF_W +: COEF_W]
//             commit_pulse  one-cycle pulse when a live set changed
//             commit_cnt    number of effective commits, wraps at 255
//             sel_err       sticky flag: update to a non-existent tile
//  Revision : 1.0  initial release
// ============================================================================
module tile_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int N_TILES  = 3,
    parameter int COEF_W   = 54
) (
    input  wire                        vga_clk,
    input  wire                        vga_rst_n,
    input  wire  [9:0]                 x,
    input  wire  [9:0]                 y,
    tile_scheduler_if.slave            upd,
    output logic [1:0]                 command,
    output logic [N_TILES*COEF_W-1:0]  coef_a,
    output logic [N_TILES*COEF_W-1:0]  coef_b,
    output logic [N_TILES*COEF_W-1:0]  coef_c,
    output logic                       commit_pulse,
    output logic [7:0]                 commit_cnt,
    output logic                       sel_err
);

    localparam logic [9:0] c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [2:0] c_N_TILES  = 3'(N_TILES);

    localparam logic [1:0] c_CMD_IDLE    = 2'd0;
    localparam logic [1:0] c_CMD_RESTART = 2'd1;
    localparam logic [1:0] c_CMD_STEPY   = 2'd2;
    localparam logic [1:0] c_CMD_STEPX   = 2'd3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_upd_ready;
    logic [1:0]         r_command;
    logic               r_commit_pulse;
    logic [7:0]         r_commit_cnt;
    logic               r_sel_err;

    logic [N_TILES-1:0] w_dirty;
    logic               w_xfer;
    logic               w_sel_ok;
    logic               w_trigger;
    logic               w_commit;
    logic               w_any_dirty;

    assign w_xfer      = upd.upd_valid && r_upd_ready;
    assign w_sel_ok    = ({1'b0, upd.upd_sel} < c_N_TILES);
    assign w_trigger   = (x == 10'd0) && (y == c_V_ACTIVE);
    assign w_commit    = (r_state == ST_COMMIT);
    assign w_any_dirty = |w_dirty;

    // ------------------------------------------------------------------------
    // Command stream: one cycle behind x/y, restart outranks stepy outranks
    // stepx.
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_command <= c_CMD_IDLE;
        end else if (y == c_V_ACTIVE) begin
            r_command <= c_CMD_RESTART;
        end else if (x == c_H_ACTIVE) begin
            r_command <= c_CMD_STEPY;
        end else if ((x < c_H_ACTIVE) && (y < c_V_ACTIVE)) begin
            r_command <= c_CMD_STEPX;
        end else begin
            r_command <= c_CMD_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Commit FSM. Ready drops for the single COMMIT cycle, so the shadow
    // registers are stable while they are being copied. An update accepted on
    // the trigger cycle is already in the shadow when COMMIT runs.
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_state        <= ST_RUN;
            r_upd_ready    <= 1'b1;
            r_commit_pulse <= 1'b0;
            r_commit_cnt   <= 8'd0;
            r_sel_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_commit_pulse <= 1'b0;
                    if (w_xfer && !w_sel_ok) begin
                        r_sel_err <= 1'b1;
                    end
                    if (w_trigger) begin
                        r_state     <= ST_COMMIT;
                        r_upd_ready <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    r_state        <= ST_RUN;
                    r_upd_ready    <= 1'b1;
                    r_commit_pulse <= w_any_dirty;
                    if (w_any_dirty) begin
                        r_commit_cnt <= r_commit_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state        <= ST_RUN;
                    r_upd_ready    <= 1'b1;
                    r_commit_pulse <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-tile shadow/live storage. A tile is rewritten in the shadow on every
    // accepted update that targets it (last write wins) and copied to live
    // only if it was written since the previous commit.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_TILES; i++) begin : g_tile
            localparam logic [1:0] c_tile_idx = 2'(i);

            logic [COEF_W-1:0] r_shadow_a;
            logic [COEF_W-1:0] r_shadow_b;
            logic [COEF_W-1:0] r_shadow_c;
            logic [COEF_W-1:0] r_live_a;
            logic [COEF_W-1:0] r_live_b;
            logic [COEF_W-1:0] r_live_c;
            logic              r_dirty;
            logic              w_wr;

            assign w_wr = w_xfer && (upd.upd_sel == c_tile_idx);

            always_ff @(posedge vga_clk or negedge vga_rst_n) begin
                if (!vga_rst_n) begin
                    r_shadow_a <= '0;
                    r_shadow_b <= '0;
                    r_shadow_c <= '0;
                    r_live_a   <= '0;
                    r_live_b   <= '0;
                    r_live_c   <= '0;
                    r_dirty    <= 1'b0;
                end else if (w_commit) begin
                    if (r_dirty) begin
                        r_live_a <= r_shadow_a;
                        r_live_b <= r_shadow_b;
                        r_live_c <= r_shadow_c;
                    end
                    r_dirty <= 1'b0;
                end else if (w_wr) begin
                    r_shadow_a <= upd.upd_a;
                    r_shadow_b <= upd.upd_b;
                    r_shadow_c <= upd.upd_c;
                    r_dirty    <= 1'b1;
                end
            end

            assign w_dirty[i]                  = r_dirty;
            assign coef_a[i*COEF_W +: COEF_W]  = r_live_a;
            assign coef_b[i*COEF_W +: COEF_W]  = r_live_b;
            assign coef_c[i*COEF_W +: COEF_W]  = r_live_c;
        end
    endgenerate

    assign upd.upd_ready = r_upd_ready;
    assign command       = r_command;
    assign commit_pulse  = r_commit_pulse;
    assign commit_cnt    = r_commit_cnt;
    assign sel_err       = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_scheduler
//  Purpose  : Self-checking bench for tile_scheduler. Drives raster positions
//             and random coefficient updates, and compares every cycle with a
//             frame-level reference model of the double-buffered coefficients.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_scheduler;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int NT = 3;
    localparam int CW = 54;

    logic             vga_clk   = 1'b0;
    logic             vga_rst_n = 1'b0;
    logic [9:0]       x = '0;
    logic [9:0]       y = '0;
    logic [1:0]       command;
    logic [NT*CW-1:0] coef_a;
    logic [NT*CW-1:0] coef_b;
    logic [NT*CW-1:0] coef_c;
    logic             commit_pulse;
    logic [7:0]       commit_cnt;
    logic             sel_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 vga_clk = ~vga_clk;

    tile_scheduler_if #(.COEF_W(CW)) bus ();

    tile_scheduler #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .N_TILES  (NT),
        .COEF_W   (CW)
    ) u_dut (
        .vga_clk      (vga_clk),
        .vga_rst_n    (vga_rst_n),
        .x            (x),
        .y            (y),
        .upd          (bus.slave),
        .command      (command),
        .coef_a       (coef_a),
        .coef_b       (coef_b),
        .coef_c       (coef_c),
        .commit_pulse (commit_pulse),
        .commit_cnt   (commit_cnt),
        .sel_err      (sel_err)
    );

    // ---------------- reference model ----------------
    logic [CW-1:0] m_sh_a [NT];
    logic [CW-1:0] m_sh_b [NT];
    logic [CW-1:0] m_sh_c [NT];
    logic [CW-1:0] m_lv_a [NT];
    logic [CW-1:0] m_lv_b [NT];
    logic [CW-1:0] m_lv_c [NT];
    bit            m_dirty [NT];
    bit            m_commit_next;
    bit            m_ready;
    bit            m_pulse;
    bit            m_err;
    int            m_cmd;
    int            m_cnt;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_sh_a[i] = '0; m_sh_b[i] = '0; m_sh_c[i] = '0;
            m_lv_a[i] = '0; m_lv_b[i] = '0; m_lv_c[i] = '0;
            m_dirty[i] = 0;
        end
        m_commit_next = 0;
        m_ready       = 1;
        m_pulse       = 0;
        m_err         = 0;
        m_cmd         = 0;
        m_cnt         = 0;
    endtask

    // What one rising edge does, given the inputs held before it.
    task automatic model_edge();
        int  xi;
        int  yi;
        int  s;
        bit  any;
        if (!vga_rst_n) begin
            model_reset();
            return;
        end
        xi = int'(x);
        yi = int'(y);
        if (yi == V)                 m_cmd = 1;
        else if (xi == H)            m_cmd = 2;
        else if (xi < H && yi < V)   m_cmd = 3;
        else                         m_cmd = 0;

        m_pulse = 0;
        if (m_commit_next) begin
            any = 0;
            for (int i = 0; i < NT; i++) begin
                if (m_dirty[i]) begin
                    m_lv_a[i] = m_sh_a[i];
                    m_lv_b[i] = m_sh_b[i];
                    m_lv_c[i] = m_sh_c[i];
                    any = 1;
                end
                m_dirty[i] = 0;
            end
            if (any) begin
                m_pulse = 1;
                m_cnt   = (m_cnt + 1) % 256;
            end
            m_commit_next = 0;
            m_ready       = 1;
        end else begin
            if (bus.upd_valid && m_ready) begin
                s = int'(bus.upd_sel);
                if (s < NT) begin
                    m_sh_a[s]  = bus.upd_a;
                    m_sh_b[s]  = bus.upd_b;
                    m_sh_c[s]  = bus.upd_c;
                    m_dirty[s] = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (xi == 0 && yi == V) begin
                m_commit_next = 1;
                m_ready       = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NT*CW-1:0] ea;
        logic [NT*CW-1:0] eb;
        logic [NT*CW-1:0] ec;
        for (int i = 0; i < NT; i++) begin
            ea[i*CW +: CW] = m_lv_a[i];
            eb[i*CW +: CW] = m_lv_b[i];
            ec[i*CW +: CW] = m_lv_c[i];
        end
        chk("command", 192'(command), 192'(m_cmd));
        chk("upd_ready", 192'(bus.upd_ready), 192'(m_ready));
        chk("commit_pulse", 192'(commit_pulse), 192'(m_pulse));
        chk("commit_cnt", 192'(commit_cnt), 192'(m_cnt));
        chk("sel_err", 192'(sel_err), 192'(m_err));
        chk("coef_a", 192'(coef_a), 192'(ea));
        chk("coef_b", 192'(coef_b), 192'(eb));
        chk("coef_c", 192'(coef_c), 192'(ec));
    endtask

    task automatic tick();
        @(posedge vga_clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic logic [CW-1:0] rand54();
        return {22'($urandom), 32'($urandom)};
    endfunction

    task automatic drive(input int xx, input int yy, input bit v, input int sel);
        x             = 10'(xx);
        y             = 10'(yy);
        bus.upd_valid = v;
        bus.upd_sel   = 2'(sel);
        bus.upd_a     = rand54();
        bus.upd_b     = rand54();
        bus.upd_c     = rand54();
    endtask

    // One raster line: either every column, or a boundary-heavy sample.
    task automatic run_line(input int yy, input int pct, input int max_sel, input bit full);
        int cols [13] = '{0, 1, 2, 3, 317, 638, 639, 640, 641, 642, 700, 839, 0};
        cols[12] = int'($urandom_range(839, 1));
        if (full) begin
            for (int xx = 0; xx < 840; xx++) begin
                drive(xx, yy, ($urandom_range(99) < pct), int'($urandom_range(max_sel)));
                tick();
            end
        end else begin
            for (int k = 0; k < 13; k++) begin
                drive(cols[k], yy, ($urandom_range(99) < pct), int'($urandom_range(max_sel)));
                tick();
            end
        end
    endtask

    task automatic run_frame(input int pct, input int max_sel, input bit full);
        int rows [11] = '{0, 1, 2, 100, 240, 478, 479, 480, 481, 499, 0};
        rows[10] = int'($urandom_range(499, 482));
        for (int r = 0; r < 11; r++) begin
            run_line(rows[r], pct, max_sel, full);
        end
    endtask

    logic [CW-1:0] val_b;
    int            cnt_before;

    initial begin
        model_reset();
        bus.upd_valid = 1'b0;
        bus.upd_sel   = 2'd0;
        bus.upd_a     = '0;
        bus.upd_b     = '0;
        bus.upd_c     = '0;

        // Reset state
        repeat (3) @(posedge vga_clk);
        #1;
        check_all();
        vga_rst_n = 1'b1;

        // Full-width sweep, no updates: command map, coefs stay zero
        run_frame(0, 2, 1'b1);

        // Directed tile 0 write at y=100, observe commit timing
        drive(5, 100, 1, 0);
        bus.upd_a = 54'h3ff7dfffb00097;
        bus.upd_b = 54'h3ff9d000880041;
        bus.upd_c = 54'h10bacff0ab114c;
        tick();
        run_line(478, 0, 2, 1'b0);
        run_line(479, 0, 2, 1'b0);
        drive(0, 480, 0, 0);
        tick();
        chk("t0_pre_commit", 192'(coef_a[CW-1:0]), 192'(0));
        drive(1, 480, 0, 0);
        tick();
        chk("t0_coef_a", 192'(coef_a[CW-1:0]), 192'(54'h3ff7dfffb00097));
        chk("t0_coef_c", 192'(coef_c[CW-1:0]), 192'(54'h10bacff0ab114c));
        chk("t0_pulse", 192'(commit_pulse), 192'(1));
        chk("t0_cnt", 192'(commit_cnt), 192'(1));
        drive(2, 480, 0, 0);
        tick();
        chk("t0_pulse_end", 192'(commit_pulse), 192'(0));

        // Valid held high across frame end
        run_line(479, 100, 2, 1'b0);
        run_line(480, 100, 2, 1'b0);
        run_line(481, 0, 2, 1'b0);

        // Tile 1 written twice, then an idle frame
        cnt_before = int'(commit_cnt);
        drive(10, 200, 1, 1);
        tick();
        drive(11, 200, 1, 1);
        val_b = bus.upd_a;
        tick();
        run_line(479, 0, 2, 1'b0);
        run_line(480, 0, 2, 1'b0);
        chk("t1_last_wins", 192'(coef_a[CW +: CW]), 192'(val_b));
        chk("t1_cnt_step", 192'(commit_cnt), 192'((cnt_before + 1) % 256));
        cnt_before = int'(commit_cnt);
        run_frame(0, 2, 1'b0);
        chk("idle_frame_cnt", 192'(commit_cnt), 192'(cnt_before));

        // Random traffic to valid tiles
        repeat (20) run_frame(20, 2, 1'b0);

        // Update to a non-existent tile
        drive(10, 50, 1, 3);
        tick();
        chk("sel_err_set", 192'(sel_err), 192'(1));
        run_frame(0, 2, 1'b0);
        chk("sel_err_sticky", 192'(sel_err), 192'(1));

        // Asynchronous reset mid-line with dirty tiles
        run_frame(20, 2, 1'b0);
        drive(3, 100, 1, 0);
        tick();
        drive(4, 100, 1, 2);
        tick();
        drive(5, 100, 0, 0);
        #2;
        vga_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_command", 192'(command), 192'(0));
        chk("rst_coef_a", 192'(coef_a), 192'(0));
        chk("rst_coef_b", 192'(coef_b), 192'(0));
        chk("rst_coef_c", 192'(coef_c), 192'(0));
        chk("rst_pulse", 192'(commit_pulse), 192'(0));
        chk("rst_cnt", 192'(commit_cnt), 192'(0));
        chk("rst_sel_err", 192'(sel_err), 192'(0));
        tick();
        tick();
        vga_rst_n = 1'b1;
        run_frame(0, 2, 1'b0);
        chk("post_rst_no_cnt", 192'(commit_cnt), 192'(0));

        // Random traffic including invalid tile indices
        repeat (20) run_frame(25, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Sequences the per-pixel tile evaluators (hour/min/sec hands) for the 640x480@75 VGA pipeline. Derives the restart/stepy/stepx command stream from the raster position. Owns the 54-bit a/b/c coefficient sets for each tile, double-buffered: a requester (time-keeping logic) writes shadow copies at any time, and the scheduler commits them to the live copies only at frame end, so a hand never tears mid-frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
N_TILES, 3, number of tile evaluators served (1..4)
COEF_W, 54, width of each coefficient

Ports:
vga_clk  in  1  pixel clock
vga_rst_n  in  1  reset, asynchronous assert, active-low
x  in  10  raster column from timing generator
y  in  10  raster row from timing generator
upd_valid  in  1  requester offers a coefficient update
upd_ready  out  1  scheduler accepts the update this cycle
upd_sel  in  2  target tile index
upd_a  in  COEF_W  coefficient a
upd_b  in  COEF_W  coefficient b
upd_c  in  COEF_W  coefficient c
command  out  2  to all tiles: 0 idle, 1 restart, 2 stepy, 3 stepx
coef_a  out  N_TILES*COEF_W  live a coefficients; tile i at [i*COEF_W +: COEF_W]
coef_b  out  N_TILES*COEF_W  live b coefficients, same packing
coef_c  out  N_TILES*COEF_W  live c coefficients, same packing
commit_pulse  out  1  one-cycle pulse when at least one tile's live set changed
commit_cnt  out  8  count of commits with at least one dirty tile, wraps 255->0
sel_err  out  1  sticky: an update with upd_sel >= N_TILES was accepted

Behaviour:
- Reset (vga_rst_n low, async): command=0, all live and shadow coefs=0, dirty bits=0, commit_pulse=0, commit_cnt=0, sel_err=0, state=RUN, upd_ready=1 after release.
- Command is registered, one cycle latency from x/y:
  - y==V_ACTIVE -> 1 (restart).
  - Else x==H_ACTIVE -> 2 (stepy).
  - Else x<H_ACTIVE && y<V_ACTIVE -> 3 (stepx).
  - Else 0.
  - Priority is in that order.
- Handshake: a transfer occurs on a cycle with upd_valid && upd_ready. On transfer with upd_sel<N_TILES: write shadow[upd_sel] = {a,b,c}; set dirty[upd_sel]. On transfer with upd_sel>=N_TILES: data dropped, sel_err set and held until reset. Repeated writes to one tile before commit: last write wins.
- FSM, two states:
  - RUN -> COMMIT when (x==0 && y==V_ACTIVE) is sampled.
  - COMMIT lasts exactly one cycle, then RUN.
  - upd_ready = (state==RUN). Ready is low only in COMMIT, so a shadow write never coincides with a commit.
- In COMMIT: for every i with dirty[i], copy shadow[i] to live[i] and clear dirty[i]. Non-dirty tiles are untouched. If any dirty: commit_pulse=1 next cycle and commit_cnt+1. If none dirty: no pulse, no count.
- Live outputs change only in the cycle after COMMIT, i.e. during line V_ACTIVE while command is 1. Tiles latch coefficients on their restart cycles, so the new values apply from the next frame's first pixel.
- An update accepted in the same cycle x==0,y==V_ACTIVE is sampled lands in shadow before COMMIT and is included in that commit.
- Updates accepted after COMMIT wait for the next frame end.
- x/y outside range (x>=H_ACTIVE+...): no special handling beyond the command rules.
- Reset mid-update or mid-commit: everything returns to reset values; partial data is discarded.

Test Plan:
1. Release reset, sweep one full 840x500 frame -> command: 3 for x<640,y<480; 2 at x==640; 1 for all of line 480; 0 elsewhere. Each value lags x/y by one cycle. coef_* all 0.
2. Write tile 0 a/b/c = 54'h3ff7dfffb00097 / 54'h3ff9d000880041 / 54'h10bacff0ab114c at y=100 -> coef_a[53:0] stays 0 until one cycle after x=0,y=480. It then equals the written value, commit_pulse is high for 1 cycle, and commit_cnt=1.
3. Hold upd_valid high continuously across x=0,y=480 -> upd_ready low for exactly one cycle, with no lost or duplicated shadow write. The write at the trigger cycle is included in the commit.
4. Write tile 1 twice (values A then B) in one frame, tile 2 untouched -> after commit: tile 1=B, tile 2 unchanged, commit_cnt increments by exactly 1. The next frame with no writes gives no pulse and no count change.
5. Write with upd_sel=3 (N_TILES=3) -> accepted (ready high); sel_err=1 and stays 1; no live or shadow change.
6. Assert vga_rst_n low while dirty bits are set, mid-line -> all outputs are 0 immediately (async). After release, the next frame end produces no commit_pulse.
